// File: rtl/mmm_mod_pkg.sv
// Shared definitions for the mmm modular add/sub blocks: FSM state encoding and default sizing.
// No logic; imported by mmm_mod_sub and mmm_mod_corr.
package mmm_mod_pkg;

    localparam int DEF_WIDTH    = 260;
    localparam int DEF_MAX_ITER = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORR = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/mmm_mod_corr.sv
// One modular correction step: classify acc against [0, p) and form acc+p / acc-p / hold.
// Purely combinational, zero latency; no handshake.
module mmm_mod_corr #(
    parameter int WIDTH = mmm_mod_pkg::DEF_WIDTH
) (
    input  logic [WIDTH+1:0] acc,
    input  logic [WIDTH-1:0] p,
    output logic             neg,
    output logic             ge_p,
    output logic             done,
    output logic [WIDTH+1:0] acc_nxt
);

    logic [WIDTH+1:0] p_ext;

    always_comb begin
        p_ext = {2'b00, p};
        neg   = acc[WIDTH+1];
        // Unsigned compare is only meaningful once acc is known non-negative.
        ge_p  = !neg && (acc >= p_ext);
        done  = !neg && !ge_p;
        if (neg) begin
            acc_nxt = acc + p_ext;
        end else if (ge_p) begin
            acc_nxt = acc - p_ext;
        end else begin
            acc_nxt = acc;
        end
    end

endmodule

// File: rtl/mmm_mod_sub.sv
// Iterative c = (a - b) mod p with +p/-p correction steps; o_iter present with MMM_MOD_SUB_CNT_EN.
// Latency 2+k cycles (k corrections), 1 on p==0, MAX_ITER+2 on cap abort; result held while i_ready=0.
module mmm_mod_sub
    import mmm_mod_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_ITER = DEF_MAX_ITER,
    parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic [WIDTH-1:0]  i_p,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WIDTH-1:0]  o_c,
`ifdef MMM_MOD_SUB_CNT_EN
    output logic [ITER_W-1:0] o_iter,
`endif
    output logic              o_err
);

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH+1:0]   acc;
    logic [WIDTH-1:0]   preg;
    logic [ITER_W-1:0]  cnt;
    logic [WIDTH-1:0]   c_reg;
    logic               err_reg;

    logic               corr_neg;
    logic               corr_ge_p;
    logic               corr_done;
    logic [WIDTH+1:0]   corr_acc_nxt;
    logic               accept;
    logic               p_zero;
    logic               cap_hit;

    mmm_mod_corr #(
        .WIDTH   (WIDTH)
    ) u_corr (
        .acc     (acc),
        .p       (preg),
        .neg     (corr_neg),
        .ge_p    (corr_ge_p),
        .done    (corr_done),
        .acc_nxt (corr_acc_nxt)
    );

    assign accept  = (state == IDLE) && i_valid;
    assign p_zero  = (i_p == '0);
    assign cap_hit = (cnt == ITER_W'(MAX_ITER));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_nxt = p_zero ? OUT : CORR;
                end
            end
            CORR: begin
                if (corr_done || cap_hit) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == OUT);
        o_c     = c_reg;
        o_err   = err_reg;
    end

`ifdef MMM_MOD_SUB_CNT_EN
    assign o_iter = cnt;
`endif

    // Operands are captured only on accept; later input changes never reach acc.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc     <= '0;
            preg    <= '0;
            cnt     <= '0;
            c_reg   <= '0;
            err_reg <= 1'b0;
        end else begin
            if (accept) begin
                preg <= i_p;
                acc  <= {2'b00, i_a} - {2'b00, i_b};
                cnt  <= '0;
                if (p_zero) begin
                    c_reg   <= '0;
                    err_reg <= 1'b1;
                end
            end else if (state == CORR) begin
                if (corr_done) begin
                    c_reg   <= acc[WIDTH-1:0];
                    err_reg <= 1'b0;
                end else if (cap_hit) begin
                    c_reg   <= '0;
                    err_reg <= 1'b1;
                end else begin
                    acc <= corr_acc_nxt;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmm_mod_sub.sv
// Directed bench for mmm_mod_sub at WIDTH=8, p=13, with a second MAX_ITER=4 instance for the cap abort.
module tb_mmm_mod_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         vld, rdy, vld4, rdy4;
    logic [W-1:0] a, b, p;

    logic         o_ready, o_valid, o_err;
    logic [W-1:0] o_c;
    logic         o_ready4, o_valid4, o_err4;
    logic [W-1:0] o_c4;
`ifdef MMM_MOD_SUB_CNT_EN
    logic [4:0]   o_iter;
    logic [2:0]   o_iter4;
`endif

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    mmm_mod_sub #(.WIDTH(W), .MAX_ITER(16)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (vld),
        .o_ready (o_ready),
        .i_a     (a),
        .i_b     (b),
        .i_p     (p),
        .o_valid (o_valid),
        .i_ready (rdy),
        .o_c     (o_c),
`ifdef MMM_MOD_SUB_CNT_EN
        .o_iter  (o_iter),
`endif
        .o_err   (o_err)
    );

    mmm_mod_sub #(.WIDTH(W), .MAX_ITER(4)) dut4 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (vld4),
        .o_ready (o_ready4),
        .i_a     (a),
        .i_b     (b),
        .i_p     (p),
        .o_valid (o_valid4),
        .i_ready (rdy4),
        .o_c     (o_c4),
`ifdef MMM_MOD_SUB_CNT_EN
        .o_iter  (o_iter4),
`endif
        .o_err   (o_err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Latency counts accept edge T as 0; o_valid seen just after edge T+n-1 is sampled at edge T+n.
    task automatic wait_res(output int l);
        l = 1;
        while (!o_valid && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ip);
        @(negedge clk);
        chk("ready_before_accept", 32'(o_ready), 32'd1);
        a = ia; b = ib; p = ip; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
    endtask

    task automatic check_res(input string tag, input int exp_lat, input logic [W-1:0] exp_c,
                             input logic exp_err, input int exp_it);
        int l;
        wait_res(l);
        chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
        chk({tag, "_c"}, 32'(o_c), 32'(exp_c));
        chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
`ifdef MMM_MOD_SUB_CNT_EN
        chk({tag, "_iter"}, 32'(o_iter), 32'(exp_it));
`else
        if (exp_it < 0) $display("unexpected iteration count %0d", exp_it);
`endif
    endtask

    task automatic consume();
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        chk("ready_after_consume", 32'(o_ready), 32'd1);
        chk("valid_after_consume", 32'(o_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; rdy = 1'b0; vld4 = 1'b0; rdy4 = 1'b0;
        a = '0; b = '0; p = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_c", 32'(o_c), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
`ifdef MMM_MOD_SUB_CNT_EN
        chk("rst_iter", 32'(o_iter), 32'd0);
`endif

        // 10 - 3 = 7, already in range
        issue(8'd10, 8'd3, 8'd13);
        check_res("c1", 2, 8'd7, 1'b0, 0);
        consume();

        // 3 - 10 = -7 -> +13 -> 6
        issue(8'd3, 8'd10, 8'd13);
        check_res("c2", 3, 8'd6, 1'b0, 1);
        consume();

        // 200 - 3 = 197 = 15*13 + 2, then backpressure hold
        issue(8'd200, 8'd3, 8'd13);
        check_res("c3", 17, 8'd2, 1'b0, 15);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_c", 32'(o_c), 32'd2);
            chk("hold_err", 32'(o_err), 32'd0);
            chk("hold_ready", 32'(o_ready), 32'd0);
        end
        consume();

        // p == 0 -> immediate error
        issue(8'd5, 8'd1, 8'd0);
        check_res("c4p0", 1, 8'd0, 1'b1, 0);
        consume();

        // cap overrun on the MAX_ITER=4 instance
        @(negedge clk);
        a = 8'd200; b = 8'd3; p = 8'd13; vld4 = 1'b1;
        @(posedge clk); #1;
        vld4 = 1'b0;
        lat = 1;
        while (!o_valid4 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("cap_lat", 32'(lat), 32'd6);
        chk("cap_err", 32'(o_err4), 32'd1);
        chk("cap_c", 32'(o_c4), 32'd0);
`ifdef MMM_MOD_SUB_CNT_EN
        chk("cap_iter", 32'(o_iter4), 32'd4);
`endif
        @(negedge clk);
        rdy4 = 1'b1;
        @(posedge clk); #1;
        rdy4 = 1'b0;
        chk("cap_ready_after", 32'(o_ready4), 32'd1);

        // reset in the middle of a long correction run
        issue(8'd200, 8'd3, 8'd13);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_c", 32'(o_c), 32'd0);
        issue(8'd10, 8'd3, 8'd13);
        check_res("c5", 2, 8'd7, 1'b0, 0);
        consume();

        // back-to-back with i_valid held high and operands changing while busy
        @(negedge clk);
        a = 8'd10; b = 8'd3; p = 8'd13; vld = 1'b1;
        @(posedge clk); #1;
        chk("b2b_busy_ready", 32'(o_ready), 32'd0);
        a = 8'd3; b = 8'd10;
        check_res("b2b1", 2, 8'd7, 1'b0, 0);
        chk("b2b_out_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        chk("b2b_idle_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b_accept2", 32'(o_ready), 32'd0);
        a = 8'd200; b = 8'd3; vld = 1'b0;
        check_res("b2b2", 3, 8'd6, 1'b0, 1);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
